sys_rst_ctrl: RTL and testbench
===============================

SYS_RST_CTRL -- requirements
Module: sys_rst_ctrl

Interface
REQ-001 Parameter LOCK_WAIT, default 16: consecutive cycles `locked` must stay high before reset sequencing proceeds.
REQ-002 Parameter RST_HOLD, default 8: cycles `sys_rst` stays asserted after lock is deemed stable.
REQ-003 Parameter DEBOUNCE, default 4: consecutive identical synchronized samples needed to accept a new `btn_step` level.
REQ-004 clk  input  1  single system clock; every flop is on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 locked  input  1  clock-generator lock status; asynchronous to `clk`, so it is double-synchronized.
REQ-007 btn_step  input  1  raw single-step push button; asynchronous and bouncy.
REQ-008 run_mode  input  1  1 = continuous run, 0 = single-step; quasi-static.
REQ-009 sys_rst  output  1  registered active-high synchronous reset to the CPU pipeline.
REQ-010 cpu_en  output  1  registered clock enable to the CPU pipeline.
REQ-011 state  output  2  current FSM state for debug display.
REQ-012 lock_loss_cnt  output  8  saturating count of lock losses while in RUN.

Function
REQ-013 The FSM SHALL have four states: WAIT_LOCK=0, LOCK_STABLE=1, HOLD_RST=2, RUN=3.
REQ-014 WAIT_LOCK: go to LOCK_STABLE and clear the cycle counter when synchronized `locked` (lk_s) = 1.
REQ-015 LOCK_STABLE: counter increments each cycle; lk_s=0 returns to WAIT_LOCK; counter = LOCK_WAIT-1 goes to HOLD_RST with counter cleared.
REQ-016 HOLD_RST: counter increments; lk_s=0 returns to WAIT_LOCK; counter = RST_HOLD-1 goes to RUN.
REQ-017 RUN: lk_s=0 goes to WAIT_LOCK and increments `lock_loss_cnt`, saturating at 255; otherwise stay in RUN.
REQ-018 Lock drop SHALL take priority over counter terminal count in the same cycle.
REQ-019 `sys_rst` SHALL be 1 in every cycle where registered state != RUN and 0 in RUN; it is a dedicated flop loaded from next-state.
REQ-020 With `locked` steady high, `sys_rst` SHALL fall exactly 2+1+LOCK_WAIT+RST_HOLD clk edges after `locked` rises (2 synchronizer stages; 27 at defaults).
REQ-021 `cpu_en` SHALL be 0 whenever `sys_rst`=1.
REQ-022 In RUN with run_mode=1, `cpu_en`=1 every cycle.
REQ-023 In RUN with run_mode=0, `cpu_en`=1 for exactly one cycle per accepted press.
REQ-024 Debounce: `btn_step` is 2-FF synchronized; the accepted level updates only after DEBOUNCE consecutive equal samples that differ from the current accepted level; any differing sample restarts the count.
REQ-025 A 0->1 transition of the accepted level SHALL generate a one-cycle step pulse; `cpu_en` follows it one cycle later.
REQ-026 Step pulses arriving outside RUN, or with run_mode=1, SHALL be discarded, never queued.
REQ-027 A run_mode change during RUN SHALL take effect on the next cycle's `cpu_en`.

Reset
REQ-028 `rst`=1 SHALL, at the next edge, force: state=WAIT_LOCK, sys_rst=1, cpu_en=0, counters=0, synchronizers=0, accepted button level=0, lock_loss_cnt=0.
REQ-029 `rst` asserted mid-sequence or in RUN SHALL restart the full lock-wait sequence; `rst` has priority over every other event.

Structure
REQ-030 State encodings and parameter defaults SHALL reside in the shared define.vh header.
REQ-031 The synchronizer, debouncer and edge detector SHALL form one sub-module, btn_debounce (ports: clk, rst, btn_in, level, rise_pulse).
REQ-032 Counter width SHALL be sized to cover max(LOCK_WAIT, RST_HOLD); the implementation is estimated at 150-250 lines.

Verification
REQ-033 Power-up: rst for 3 cycles, locked=1 from cycle 5 -> sys_rst falls 27 cycles after locked rises; cpu_en=1 thereafter with run_mode=1.
REQ-034 Lock glitch: locked low for 1 cycle at count 10 of LOCK_STABLE -> state returns to WAIT_LOCK; full 27-cycle delay is measured from re-lock.
REQ-035 Lock loss in RUN: locked drops -> sys_rst=1 and cpu_en=0 within 3 cycles; lock_loss_cnt=1; after 300 losses lock_loss_cnt=255.
REQ-036 Bounce: run_mode=0; btn_step toggles every cycle for 10 cycles, then held high 20 cycles -> exactly one cpu_en pulse; release and press again -> second single pulse.
REQ-037 Discard: press during HOLD_RST -> no cpu_en pulse after entering RUN.
REQ-038 Reset in RUN: rst for 1 cycle -> next edge sys_rst=1, state=0, lock_loss_cnt=0; release after a further 27 cycles with locked held high.

Source files
------------

// File: rtl/sys_rst_ctrl_pkg.sv
// Shared types and defaults for the system reset controller.
// State encoding and parameter defaults live here.
package sys_rst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK   = 2'd0,
    ST_LOCK_STABLE = 2'd1,
    ST_HOLD_RST    = 2'd2,
    ST_RUN         = 2'd3
  } state_e;

  localparam int unsigned LOCK_WAIT_DEF = 16;
  localparam int unsigned RST_HOLD_DEF  = 8;
  localparam int unsigned DEBOUNCE_DEF  = 4;

  localparam logic [7:0] LOSS_MAX = 8'hFF;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sys_rst_ctrl_btn_debounce.sv
// Step button synchronizer, debouncer and rising-edge detector.
// Accepted level moves only after DEBOUNCE equal differing samples.
module btn_debounce
  import sys_rst_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned DW =
    (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE - 1);

  logic          m_q, m_d;
  logic          s_q, s_d;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Sample chain, debounce counter and edge detect.
  always_comb begin
    m_d   = btn_in;
    s_d   = m_q;
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s_q != lvl_q) begin
      if (cnt_q == DB_TC) begin
        lvl_d = s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = lvl_d & ~lvl_q;
  end

  // Register stage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= 1'b0;
      s_q    <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      m_q    <= m_d;
      s_q    <= s_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level      = lvl_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/sys_rst_ctrl.sv
// System reset sequencer: waits for stable lock, holds reset,
// then enables the CPU continuously or one step per press.
module sys_rst_ctrl
  import sys_rst_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_WAIT = LOCK_WAIT_DEF,
  parameter int unsigned RST_HOLD  = RST_HOLD_DEF,
  parameter int unsigned DEBOUNCE  = DEBOUNCE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       btn_step,
  input  logic       run_mode,
  output logic       sys_rst,
  output logic       cpu_en,
  output logic [1:0] state,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned CMAX = max2(LOCK_WAIT, RST_HOLD);
  localparam int unsigned CW =
    (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] LW_TC = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] RH_TC = CW'(RST_HOLD - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    loss_q, loss_d;
  logic          lk_m_q, lk_m_d;
  logic          lk_s_q, lk_s_d;
  logic          sys_rst_q, sys_rst_d;
  logic          cpu_en_q, cpu_en_d;
  logic          btn_level;
  logic          step_pulse;

  btn_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_btn (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_step),
    .level      (btn_level),
    .rise_pulse (step_pulse)
  );

  // Next state, counters and registered outputs.
  always_comb begin
    lk_m_d  = locked;
    lk_s_d  = lk_m_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_s_q) state_d = ST_LOCK_STABLE;
      end
      ST_LOCK_STABLE: begin
        if (!lk_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == LW_TC) begin
          state_d = ST_HOLD_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD_RST: begin
        if (!lk_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == RH_TC) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lk_s_q) begin
          state_d = ST_WAIT_LOCK;
          if (loss_q != LOSS_MAX) begin
            loss_d = loss_q + 8'd1;
          end
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
    sys_rst_d = (state_d != ST_RUN);
    cpu_en_d  = (state_d == ST_RUN) &&
                (run_mode ||
                 ((state_q == ST_RUN) && step_pulse));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      loss_q    <= 8'd0;
      lk_m_q    <= 1'b0;
      lk_s_q    <= 1'b0;
      sys_rst_q <= 1'b1;
      cpu_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      lk_m_q    <= lk_m_d;
      lk_s_q    <= lk_s_d;
      sys_rst_q <= sys_rst_d;
      cpu_en_q  <= cpu_en_d;
    end
  end

  assign sys_rst       = sys_rst_q;
  assign cpu_en        = cpu_en_q;
  assign state         = state_q;
  assign lock_loss_cnt = loss_q;

  logic unused_level;
  assign unused_level = btn_level;

endmodule

// File: tb/tb_sys_rst_ctrl.sv
// Directed bench for sys_rst_ctrl at default parameters.
// Sequencing delay, lock loss, debounce, discard and reset.
module tb_sys_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       btn_step;
  logic       run_mode;
  logic       sys_rst;
  logic       cpu_en;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;

  int n_chk = 0;
  int n_err = 0;

  sys_rst_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked),
    .btn_step      (btn_step),
    .run_mode      (run_mode),
    .sys_rst       (sys_rst),
    .cpu_en        (cpu_en),
    .state         (state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic to_fall(output int n, output bit saw0);
    n    = 0;
    saw0 = 1'b0;
    do begin
      tick;
      n++;
      if (state == 2'd0) saw0 = 1'b1;
    end while (sys_rst !== 1'b0 && n < 200);
  endtask

  task automatic wait_st(input logic [1:0] s,
                         output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulses(input int cyc, output int p);
    p = 0;
    for (int i = 0; i < cyc; i++) begin
      tick;
      if (cpu_en === 1'b1) p++;
    end
  endtask

  task automatic relock(output bit ok);
    bit a;
    int n;
    bit s;
    locked = 1'b0;
    wait_st(2'd0, a);
    locked = 1'b1;
    to_fall(n, s);
    ok = a && (n == 27);
  endtask

  initial begin
    int  n;
    int  p;
    int  bad;
    bit  ok;
    bit  saw;

    rst      = 1'b1;
    locked   = 1'b0;
    btn_step = 1'b0;
    run_mode = 1'b1;
    repeat (3) tick;
    chk("rst_state", state, 0);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_loss", lock_loss_cnt, 0);

    rst = 1'b0;
    tick;
    locked = 1'b1;
    to_fall(n, saw);
    chk("pwrup_delay", n, 27);
    chk("pwrup_state", state, 3);
    chk("pwrup_cpu_en", cpu_en, 1);
    tick;
    chk("run_cpu_en", cpu_en, 1);

    locked = 1'b0;
    n = 0;
    do begin
      tick;
      n++;
    end while (sys_rst !== 1'b1 && n < 20);
    chk("loss_latency", n, 3);
    chk("loss_cpu_en", cpu_en, 0);
    chk("loss_state", state, 0);
    chk("loss_cnt1", lock_loss_cnt, 1);

    locked = 1'b1;
    wait_st(2'd1, ok);
    chk("glitch_enter_ls", ok, 1);
    repeat (8) tick;
    locked = 1'b0;
    tick;
    locked = 1'b1;
    to_fall(n, saw);
    chk("glitch_saw_wait", saw, 1);
    chk("glitch_delay", n, 27);
    chk("glitch_no_loss", lock_loss_cnt, 1);

    bad = 0;
    for (int i = 0; i < 253; i++) begin
      relock(ok);
      if (!ok) bad++;
    end
    chk("loss_254", lock_loss_cnt, 254);
    relock(ok);
    if (!ok) bad++;
    chk("loss_255", lock_loss_cnt, 255);
    for (int i = 0; i < 45; i++) begin
      relock(ok);
      if (!ok) bad++;
    end
    chk("loss_sat_300", lock_loss_cnt, 255);
    chk("relock_loop", bad, 0);

    tick;
    chk("mode_run", cpu_en, 1);
    run_mode = 1'b0;
    tick;
    chk("mode_step_next", cpu_en, 0);

    p = 0;
    for (int i = 0; i < 10; i++) begin
      btn_step = (i % 2 == 0);
      tick;
      if (cpu_en === 1'b1) p++;
    end
    chk("bounce_only", p, 0);
    btn_step = 1'b1;
    pulses(20, n);
    chk("bounce_press", p + n, 1);
    btn_step = 1'b0;
    pulses(20, n);
    chk("release", n, 0);
    btn_step = 1'b1;
    pulses(20, n);
    chk("press2", n, 1);

    run_mode = 1'b1;
    btn_step = 1'b0;
    repeat (20) tick;
    btn_step = 1'b1;
    repeat (20) tick;
    run_mode = 1'b0;
    pulses(10, n);
    chk("discard_run_mode", n, 0);

    btn_step = 1'b0;
    repeat (20) tick;
    locked = 1'b0;
    wait_st(2'd0, ok);
    locked = 1'b1;
    wait_st(2'd2, ok);
    chk("hold_reached", ok, 1);
    btn_step = 1'b1;
    wait_st(2'd3, ok);
    chk("hold_to_run", ok, 1);
    pulses(20, n);
    chk("discard_hold", n, 0);

    run_mode = 1'b1;
    tick;
    chk("pre_rst_run", cpu_en, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rrun_sys_rst", sys_rst, 1);
    chk("rrun_state", state, 0);
    chk("rrun_loss", lock_loss_cnt, 0);
    chk("rrun_cpu_en", cpu_en, 0);
    to_fall(n, saw);
    chk("rrun_delay", n, 27);
    chk("rrun_state_run", state, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
